sum_serial_ctrl: RTL
====================

Name: sum_serial_ctrl

Overview:
- Bit-serial add/subtract controller that time-shares one full-adder cell (a, b, ci -> so, co) across the N bits of two operands.
- Sequences the cell LSB-first, one bit per clock. Holds the operand and result shift registers and the carry flip-flop.
- Exposes a start/busy/done handshake toward the surrounding FPGA datapath.
- The full-adder cell is instantiated inside this block and driven only by it.

Parameters:
- N, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled on the rising edge of clk.
- sub  input  1  0 = a+b+ci_in; 1 = a-b-ci_in (ci_in acts as borrow-in).
- a  input  N  operand A, captured on an accepted start.
- b  input  N  operand B, captured on an accepted start.
- ci_in  input  1  carry-in (add) or borrow-in (sub), captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: the result is valid.
- s  output  N  sum/difference; held stable from done until the next accepted start completes.
- co  output  1  carry out of the MSB. For sub: 1 = no borrow.
- ov  output  1  signed (two's complement) overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, busy=0, done=0, s=0, co=0, ov=0.
  - Internal shift registers, carry flip-flop and bit counter cleared.
  - An operation in progress is abandoned, with no done pulse.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, RUN, DONE.
- Start accept: start=1 sampled at an edge while state is IDLE or DONE (busy=0). On that edge:
  - ra<=a, rb<=b XOR {N{sub}}, carry<=ci_in XOR sub, cnt<=0, state<=RUN.
- start while busy=1: ignored, with no effect on the current operation.
- RUN (busy=1), one bit per cycle:
  - The cell sees a=ra[0], b=rb[0], ci=carry.
  - At the edge: ra and rb shift right by 1; so shifts into the result register from the MSB side; carry<=cell co; cnt<=cnt+1.
  - On the edge where cnt==N-1: record the carry into the MSB (the cell's ci) for ov, load the final cell co into co, state<=DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE unless a new start is accepted on that edge.
- Timing: start accepted at edge k -> busy=1 in cycles k+1..k+N -> done=1 in cycle k+N+1.
  - Latency is N+1 cycles from accept to done.
  - Back-to-back operations: one result every N+1 cycles.
- Output hold: s, co and ov update only at the RUN->DONE transition.
  - Internally, the result shift register is separate from the s output register, so s never shows partial results.
  - s, co and ov stay stable through IDLE and the next RUN until that run's completion.
- Width rules:
  - Arithmetic is modulo 2^N.
  - cnt is wide enough to hold N-1 (clog2(N), minimum 1 bit).
  - N=1: a single RUN cycle; ov = ci XOR co of that bit.
- Inputs a, b, sub and ci_in are don't-care except on the accepting edge.

Test Plan:
- Add, N=8: a=0x5A, b=0x3C, sub=0, ci_in=0, start pulse -> busy high 8 cycles, then done for 1 cycle with s=0x96, co=0, ov=1.
- Add wrap: a=0xFF, b=0x01, ci_in=0 -> s=0x00, co=1, ov=0. Repeat with ci_in=1 -> s=0x01, co=1, ov=0.
- Subtract:
  - a=0x10, b=0x20, sub=1, ci_in=0 -> s=0xF0, co=0 (borrow), ov=0.
  - a=0x80, b=0x01, sub=1 -> s=0x7F, co=1, ov=1.
- Handshake:
  - start held high continuously with a=0x01, b=0x02 -> result every 9 cycles, done one cycle wide, s=0x03.
  - start pulses in mid-RUN are ignored: operands changed mid-run leave the result unchanged.
- Reset mid-operation: rst_n low during cycle 4 of RUN -> busy, done, s, co and ov go to 0 immediately, with no done afterwards. A new start after release gives a correct result (0x05+0x03 -> 0x08).
- Hold check: after done with s=0x96, the next start with 0x01+0x01 keeps s=0x96 throughout RUN. s changes to 0x02 only in the done cycle.

Source files
------------

// File: rtl/sum_serial_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is time-shared LSB-first
// across N bits, with a start/busy/done handshake and held result outputs.

module sum_serial_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic so,
  output logic co
);
  assign so = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module sum_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         co,
  output logic         ov
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state;
  logic [N-1:0]   r_ra;
  logic [N-1:0]   r_rb;
  logic [N-1:0]   r_res;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_s;
  logic           r_co;
  logic           r_ov;
  logic           r_busy;
  logic           r_done;

  logic           w_so;
  logic           w_co;
  logic [N-1:0]   w_res_next;

  sum_serial_fa u_fa (
    .a  (r_ra[0]),
    .b  (r_rb[0]),
    .ci (r_carry),
    .so (w_so),
    .co (w_co)
  );

  // Result bits enter from the MSB side; a 1-bit result is just the cell output.
  generate
    if (N == 1) begin : g_res_one
      assign w_res_next = w_so;
    end else begin : g_res_wide
      assign w_res_next = {w_so, r_res[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction as a + ~b + ~borrow_in.
            r_ra    <= a;
            r_rb    <= b ^ {N{sub}};
            r_carry <= ci_in ^ sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_ra    <= r_ra >> 1;
          r_rb    <= r_rb >> 1;
          r_res   <= w_res_next;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_s     <= w_res_next;
            r_co    <= w_co;
            r_ov    <= r_carry ^ w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign co   = r_co;
  assign ov   = r_ov;
endmodule
